ann_mac_sequencer: RTL and testbench

//  Sequences one shared multiply-accumulate datapath through the 2-3-5-1 ternary-XOR network.

---
 rtl/ann_mac_sequencer_if.sv | 33 +++
 rtl/ann_mac_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_ann_mac_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ann_mac_sequencer_if.sv
// Weight-ROM read port and tanh-unit handshake seen by the MAC sequencer.
// master = sequencer side, slave = ROM / activation side.
interface ann_mac_sequencer_if #(
    parameter int DW = 16
);
    logic          w_rd_en;
    logic [4:0]    w_addr;
    logic [DW-1:0] w_rdata;
    logic          act_req;
    logic [DW-1:0] act_in;
    logic          act_ack;
    logic [DW-1:0] act_out;

    modport master (
        output w_rd_en,
        output w_addr,
        input  w_rdata,
        output act_req,
        output act_in,
        input  act_ack,
        input  act_out
    );

    modport slave (
        input  w_rd_en,
        input  w_addr,
        output w_rdata,
        input  act_req,
        input  act_in,
        output act_ack,
        output act_out
    );
endinterface

// File: rtl/ann_mac_sequencer.sv
// Shared-MAC sequencer for the 2-3-5-1 ternary-XOR network.
// Streams weights from an external ROM, hands pre-activations to a shared tanh.
module ann_mac_sequencer #(
    parameter int DW    = 16,
    parameter int FW    = 12,
    parameter int ACC_W = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          x_in,
    input  logic [1:0]          y_in,
    output logic                busy,
    output logic                done,
    output logic [1:0]          result,
    ann_mac_sequencer_if.master mac_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_MAC,
        S_L1_DRN,
        S_L1_ACT,
        S_L2_MAC,
        S_L2_DRN,
        S_L2_ACT,
        S_DONE
    } state_e;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
    localparam logic signed [DW-1:0]    HALF   = DW'(2 ** (FW - 1));

    state_e                   state_q, state_d;
    logic [2:0]               j_q, j_d;
    logic [2:0]               k_q, k_d;
    logic [1:0]               x_q, x_d;
    logic [1:0]               y_q, y_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]     h_q [5];
    logic signed [DW-1:0]     h_d [5];
    logic [1:0]               pend_q, pend_d;
    logic [1:0]               result_q, result_d;
    logic                     done_q, done_d;

    // Tag of the read whose data is on w_rdata this cycle.
    logic                     rd_vld_q;
    logic [2:0]               rd_k_q;
    logic                     rd_l2_q;

    logic                     w_rd_en;
    logic [4:0]               w_addr;
    logic                     act_req;
    logic [DW-1:0]            act_sat;

    logic signed [ACC_W-1:0]  w_ext;
    logic signed [DW-1:0]     h_sel;
    logic signed [2*DW-1:0]   prod_full;
    logic signed [ACC_W-1:0]  prod_l2;
    logic signed [ACC_W-1:0]  term;
    logic signed [DW-1:0]     act_s;

    function automatic logic signed [ACC_W-1:0] tsel(
        input logic [1:0]              t,
        input logic signed [ACC_W-1:0] w
    );
        logic signed [ACC_W-1:0] r;
        case (t)
            2'b01:   r = w;
            2'b11:   r = -w;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign w_ext = ACC_W'($signed(mac_if.w_rdata));

    always_comb begin
        h_sel = '0;
        case (rd_k_q)
            3'd1:    h_sel = h_q[0];
            3'd2:    h_sel = h_q[1];
            3'd3:    h_sel = h_q[2];
            3'd4:    h_sel = h_q[3];
            3'd5:    h_sel = h_q[4];
            default: h_sel = '0;
        endcase
    end

    // Full-width product, arithmetic shift floors toward -inf.
    assign prod_full = $signed(mac_if.w_rdata) * h_sel;
    assign prod_l2   = ACC_W'(prod_full >>> FW);

    // Bias terms multiply by 1.0, ternary terms are select/negate.
    always_comb begin
        term = w_ext;
        if (rd_k_q != 3'd0) begin
            if (rd_l2_q)
                term = prod_l2;
            else if (rd_k_q == 3'd1)
                term = tsel(x_q, w_ext);
            else
                term = tsel(y_q, w_ext);
        end
    end

    always_comb begin
        if (acc_q > SAT_HI)
            act_sat = SAT_HI[DW-1:0];
        else if (acc_q < SAT_LO)
            act_sat = SAT_LO[DW-1:0];
        else
            act_sat = acc_q[DW-1:0];
    end

    assign act_s = $signed(mac_if.act_out);

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        x_d      = x_q;
        y_d      = y_q;
        h_d      = h_q;
        acc_d    = rd_vld_q ? acc_q + term : acc_q;
        pend_d   = pend_q;
        result_d = result_q;
        done_d   = 1'b0;
        w_rd_en  = 1'b0;
        w_addr   = '0;
        act_req  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_L1_MAC;
                    x_d     = x_in;
                    y_d     = y_in;
                    acc_d   = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_L1_MAC: begin
                w_rd_en = 1'b1;
                w_addr  = {2'b00, k_q} * 5'd5 + {2'b00, j_q};
                if (k_q == 3'd2) begin
                    k_d     = '0;
                    state_d = S_L1_DRN;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_L1_DRN: state_d = S_L1_ACT;
            S_L1_ACT: begin
                act_req = 1'b1;
                if (mac_if.act_ack) begin
                    h_d[j_q] = mac_if.act_out;
                    acc_d    = '0;
                    k_d      = '0;
                    if (j_q == 3'd4) begin
                        j_d     = '0;
                        state_d = S_L2_MAC;
                    end else begin
                        j_d     = j_q + 3'd1;
                        state_d = S_L1_MAC;
                    end
                end
            end
            S_L2_MAC: begin
                w_rd_en = 1'b1;
                w_addr  = 5'd15 + {2'b00, k_q};
                if (k_q == 3'd5) begin
                    k_d     = '0;
                    state_d = S_L2_DRN;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_L2_DRN: state_d = S_L2_ACT;
            S_L2_ACT: begin
                act_req = 1'b1;
                if (mac_if.act_ack) begin
                    // Strict thresholds: exactly +/-0.5 maps to 0.
                    if (act_s > HALF)
                        pend_d = 2'b01;
                    else if (act_s < -HALF)
                        pend_d = 2'b11;
                    else
                        pend_d = 2'b00;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d = pend_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            j_q      <= '0;
            k_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            for (int i = 0; i < 5; i++)
                h_q[i] <= '0;
            pend_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_k_q   <= '0;
            rd_l2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            k_q      <= k_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            h_q      <= h_d;
            pend_q   <= pend_d;
            result_q <= result_d;
            done_q   <= done_d;
            rd_vld_q <= w_rd_en;
            rd_k_q   <= k_q;
            rd_l2_q  <= (state_q == S_L2_MAC);
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign result         = result_q;
    assign mac_if.w_rd_en = w_rd_en;
    assign mac_if.w_addr  = w_addr;
    assign mac_if.act_req = act_req;
    assign mac_if.act_in  = act_req ? act_sat : '0;

endmodule

// File: tb/tb_ann_mac_sequencer.sv
// Bench for ann_mac_sequencer: ROM + tanh stand-ins and a
// behavioural network model evaluated with plain integer arithmetic.
`timescale 1ns/1ps
module tb_ann_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] x_in = 2'b00;
    logic [1:0] y_in = 2'b00;
    logic       busy, done;
    logic [1:0] result;

    ann_mac_sequencer_if #(.DW(16)) bus ();

    ann_mac_sequencer #(.DW(16), .FW(12), .ACC_W(22)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x_in   (x_in),
        .y_in   (y_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .mac_if (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [21];
    int          act_mode = 0;
    int          act_lat = 1;
    int          ack_cnt = 0;
    logic        ack_noise = 1'b0;

    function automatic logic [15:0] act_fn(input logic [15:0] a, input int mode);
        if (mode == 0) return a;
        if ($signed(a) > 4096) return 16'd4096;
        if ($signed(a) < -4096) return 16'hF000;
        return a;
    endfunction

    // Registered ROM; garbage on w_rdata when no read was issued.
    always @(posedge clk) begin
        if (bus.w_rd_en && bus.w_addr <= 5'd20)
            bus.w_rdata <= rom[bus.w_addr];
        else
            bus.w_rdata <= 16'($urandom);
        ack_noise <= 1'($urandom);
        ack_cnt   <= (bus.act_req && !bus.act_ack) ? ack_cnt + 1 : 0;
    end

    assign bus.act_ack = bus.act_req ? (ack_cnt == act_lat - 1) : ack_noise;
    assign bus.act_out = act_fn(bus.act_in, act_mode);

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    logic [15:0] cap_q[$];
    bit          stab_en = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_in = '0;

    always @(negedge clk) begin
        if (bus.act_req && bus.act_ack) cap_q.push_back(bus.act_in);
        if (stab_en && rst_n && bus.act_req && prev_req && !prev_ack)
            chk("act_in_stable", bus.act_in, prev_in);
        prev_req <= bus.act_req;
        prev_ack <= bus.act_ack;
        prev_in  <= bus.act_in;
    end

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint tv(input logic [1:0] t);
        if (t == 2'b01) return 1;
        if (t == 2'b11) return -1;
        return 0;
    endfunction

    function automatic longint wrap22(input longint v);
        longint m;
        m = v & 4194303;
        if (m >= 2097152) m = m - 4194304;
        return m;
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [1:0] model(input logic [1:0] x, input logic [1:0] y,
                                         input int mode);
        longint acc;
        longint h [5];
        longint a;
        for (int j = 0; j < 5; j++) begin
            acc  = sx(rom[j]);
            acc  = wrap22(acc + tv(x) * sx(rom[5 + j]));
            acc  = wrap22(acc + tv(y) * sx(rom[10 + j]));
            h[j] = sx(act_fn(16'(sat16(acc)), mode));
        end
        acc = sx(rom[15]);
        for (int k = 1; k < 6; k++)
            acc = wrap22(acc + ((sx(rom[15 + k]) * h[k - 1]) >>> 12));
        a = sx(act_fn(16'(sat16(acc)), mode));
        if (a > 2048) return 2'b01;
        if (a < -2048) return 2'b11;
        return 2'b00;
    endfunction

    task automatic run(input logic [1:0] x, input logic [1:0] y, input bit restart,
                       output logic [1:0] res, output int lat, output bit busy_lo);
        busy_lo = 0;
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_in  = 2'($urandom);
        y_in  = 2'($urandom);
        lat   = 0;
        if (!busy) busy_lo = 1;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (restart && lat == 10) start = 1'b1;
            if (restart && lat == 13) start = 1'b0;
            if (!done && !busy) busy_lo = 1;
        end
        res = result;
        @(negedge clk);
        chk("done_single_cycle", done, 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 21; i++) rom[i] = '0;
    endtask

    logic [15:0] t3_w [6] = '{16'd3072, 16'hF400, 16'd2048, 16'd2049, 16'hF800, 16'hF7FF};
    logic [1:0]  t3_e [6] = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11};
    logic [15:0] trained [21] = '{
        16'hF000, 16'hF000, 16'h0000, 16'h0800, 16'hF800,
        16'h2000, 16'hE000, 16'h1000, 16'hF000, 16'h1800,
        16'h2000, 16'hE000, 16'hF000, 16'h1000, 16'h1800,
        16'hF800, 16'h1800, 16'h1800, 16'h0800, 16'h0800, 16'hF400
    };
    logic [1:0]  terns [3] = '{2'b11, 2'b00, 2'b01};

    initial begin
        logic [1:0] res;
        int         lat;
        int         n;
        bit         blo;
        bit         saw_done;

        clear_rom();
        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom);
            x_in  = 2'($urandom);
            y_in  = 2'($urandom);
            #1 chk("reset_outputs", {busy, done, result, bus.act_req, bus.w_rd_en}, 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_outputs", {busy, done, result, bus.act_req, bus.w_rd_en}, 0);
        end

        // All-zero ROM, identity activation
        act_mode = 0;
        act_lat  = 1;
        run(2'b01, 2'b01, 0, res, lat, blo);
        chk("zero_rom_result", res, 2'b00);
        chk("zero_rom_latency", lat, 34);
        chk("zero_rom_busy", blo, 0);

        // Output thresholds around +/-0.5
        for (int i = 0; i < 6; i++) begin
            clear_rom();
            rom[15] = t3_w[i];
            run(2'($urandom), 2'($urandom), 0, res, lat, blo);
            chk($sformatf("threshold_%0d", i), res, t3_e[i]);
        end

        // Slow activation, stray start mid-run
        for (int i = 0; i < 21; i++) rom[i] = 16'($urandom_range(0, 16383)) - 16'd8192;
        act_mode = 1;
        act_lat  = 3;
        stab_en  = 1;
        run(2'b01, 2'b11, 1, res, lat, blo);
        stab_en = 0;
        chk("slow_ack_latency", lat, 46);
        chk("slow_ack_result", res, model(2'b01, 2'b11, 1));
        chk("slow_ack_busy", blo, 0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("second_start_ignored", n, 0);

        // Saturation of layer-1 pre-activations
        act_lat = 1;
        for (int s = 0; s < 2; s++) begin
            clear_rom();
            for (int i = 0; i < 15; i++) rom[i] = (s == 0) ? 16'h7FFF : 16'h8000;
            cap_q.delete();
            run(2'b01, 2'b01, 0, res, lat, blo);
            chk("sat_capture_count", cap_q.size(), 6);
            for (int i = 0; i < 5 && i < cap_q.size(); i++)
                chk($sformatf("sat_act_in_%0d_%0d", s, i), cap_q[i],
                    (s == 0) ? 16'h7FFF : 16'h8000);
            chk("sat_result", res, model(2'b01, 2'b01, act_mode));
        end

        // Reset during L1_ACT of j=2, then trained-weight sweep
        for (int i = 0; i < 21; i++) rom[i] = trained[i];
        act_mode = 1;
        act_lat  = 2;
        cap_q.delete();
        @(negedge clk);
        x_in  = 2'b01;
        y_in  = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(bus.act_req && cap_q.size() == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_l1_act_j2", n < 200, 1);
        rst_n = 1'b0;
        #1 chk("abort_outputs", {busy, bus.act_req, bus.w_rd_en, done}, 0);
        saw_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);

        act_lat = 1;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) begin
                run(terns[a], terns[b], 0, res, lat, blo);
                chk($sformatf("trained_%0d_%0d", a, b), res, model(terns[a], terns[b], 1));
                chk("trained_latency", lat, 34);
            end

        // Randomized weights, inputs, activation mode and ack latency
        for (int it = 0; it < 12; it++) begin
            logic [1:0] rx, ry;
            for (int i = 0; i < 21; i++) rom[i] = 16'($urandom_range(0, 16383)) - 16'd8192;
            rx       = 2'($urandom);
            ry       = 2'($urandom);
            act_mode = int'($urandom_range(0, 1));
            act_lat  = int'($urandom_range(1, 4));
            run(rx, ry, 0, res, lat, blo);
            chk($sformatf("rand_result_%0d", it), res, model(rx, ry, act_mode));
            chk($sformatf("rand_latency_%0d", it), lat, 28 + 6 * act_lat);
            chk("rand_busy", blo, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
